vermibus_arbiter: RTL and testbench
===================================

VERMIBUS_ARBITER -- requirements
Module: vermibus_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requester ports (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width; multiple of 8; strobe width SW = DATA_WIDTH/8.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, responder wait limit; 0 disables timeout.
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk  in  1  clock, rising edge; reset  in  1  synchronous active-low reset.
REQ-006 m_valid  in  N_REQ  per-requester request valid.
REQ-007 m_address  in  N_REQ*ADDR_WIDTH  per-requester address, requester i at slice i.
REQ-008 m_wstrobe  in  N_REQ*SW  per-requester byte strobes; all-zero means read.
REQ-009 m_wdata  in  N_REQ*DATA_WIDTH  per-requester write data.
REQ-010 m_ready  out  N_REQ  per-requester one-cycle completion.
REQ-011 m_rdata  out  DATA_WIDTH  read data, shared by all requesters, meaningful only with m_ready.
REQ-012 m_irq  out  N_REQ  responder interrupt, broadcast.
REQ-013 s_valid, s_address, s_wstrobe, s_wdata  out  1/ADDR_WIDTH/SW/DATA_WIDTH  forwarded request.
REQ-014 s_ready, s_rdata, s_irq  in  1/DATA_WIDTH/1  responder completion, data, interrupt.
REQ-015 busy  out  1  high in BUSY state; grant  out  clog2(N_REQ) (min 1)  current/last granted index; timeout_err  out  1  one-cycle timeout pulse.

Function
REQ-016 Bus protocol SHALL be: requester holds valid, address, wstrobe, wdata stable until its ready; ready high exactly one cycle; rdata valid in that cycle.
REQ-017 FSM SHALL have two states, IDLE and BUSY.
REQ-018 In IDLE with any m_valid high, arbiter SHALL pick the first requester with valid high searching (grant+1) mod N_REQ upward, register grant, and enter BUSY next cycle.
REQ-019 In IDLE, s_valid SHALL be 0 and all m_ready SHALL be 0.
REQ-020 In BUSY, s_valid SHALL equal m_valid[grant]; s_address, s_wstrobe, s_wdata SHALL equal granted slice (combinational mux).
REQ-021 In BUSY, m_ready[grant] SHALL equal s_ready; m_ready of every other requester SHALL be 0; m_rdata SHALL equal s_rdata.
REQ-022 In BUSY, s_ready high SHALL return FSM to IDLE next cycle; grant retained as round-robin pointer.
REQ-023 Minimum latency: m_valid rising at cycle T with combinational s_ready SHALL give m_ready at T+1; back-to-back transactions SHALL each cost at least 2 cycles.
REQ-024 BUSY wait counter SHALL clear on BUSY entry and increment each BUSY cycle without s_ready; width clog2(TIMEOUT_CYCLES+1).
REQ-025 When TIMEOUT_CYCLES>0 and counter equals TIMEOUT_CYCLES-1 without s_ready, that cycle SHALL force s_valid=0, m_ready[grant]=1, m_rdata all-ones, timeout_err=1, and return to IDLE next cycle.
REQ-026 s_ready and timeout in same cycle: s_ready SHALL win (normal completion, s_rdata, no timeout_err).
REQ-027 m_valid[grant] low in BUSY (requester abort) SHALL return FSM to IDLE next cycle with no m_ready and no timeout_err.
REQ-028 m_irq[i] SHALL equal s_irq for all i, combinational, in all states.
REQ-029 busy SHALL equal (state==BUSY).
REQ-030 With N_REQ requests held continuously, each requester SHALL be granted once per N_REQ transactions (no starvation).

Reset
REQ-031 reset low at a clock edge SHALL force IDLE, grant=N_REQ-1 (requester 0 wins first), counter 0, regardless of state.
REQ-032 During and immediately after reset: s_valid=0, m_ready all 0, timeout_err=0, busy=0; an in-flight transaction SHALL be dropped without m_ready.
REQ-033 m_rdata and s_address/s_wstrobe/s_wdata SHALL be don't-care while s_valid/m_ready are 0.

Verification
REQ-034 N_REQ=2; m_valid=2'b11 held, s_ready combinational on s_valid -> grants 0,1,0,1; m_ready pulses alternate, one per 2 cycles.
REQ-035 Requester 1 write addr 0x0000_0010, wstrobe 4'b0011, wdata 0xAABB_CCDD, s_ready after 3 BUSY cycles -> s_* match exactly, m_ready[1] once, m_ready[0] never.
REQ-036 TIMEOUT_CYCLES=4, responder never ready -> m_ready[grant] and timeout_err in 4th BUSY cycle, m_rdata=0xFFFF_FFFF, busy low next cycle.
REQ-037 TIMEOUT_CYCLES=4, s_ready in 4th BUSY cycle, s_rdata=0x1234_5678 -> m_rdata=0x1234_5678, timeout_err stays 0.
REQ-038 reset low in BUSY while s_ready=0 -> next cycle busy=0, s_valid=0, no m_ready; after release with m_valid=2'b11 requester 0 granted first.
REQ-039 s_irq toggled in IDLE and BUSY -> all m_irq bits follow same cycle.

Source files
------------

// File: rtl/vermibus_arbiter.sv
// Round-robin arbiter forwarding one of N_REQ requesters onto a single responder bus,
// with an optional responder wait limit that completes a stalled transfer with all-ones data.
module vermibus_arbiter #(
    parameter int N_REQ          = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [N_REQ-1:0]                       m_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0]            m_address,
    input  logic [N_REQ*(DATA_WIDTH/8)-1:0]        m_wstrobe,
    input  logic [N_REQ*DATA_WIDTH-1:0]            m_wdata,
    output logic [N_REQ-1:0]                       m_ready,
    output logic [DATA_WIDTH-1:0]                  m_rdata,
    output logic [N_REQ-1:0]                       m_irq,
    output logic                                   s_valid,
    output logic [ADDR_WIDTH-1:0]                  s_address,
    output logic [DATA_WIDTH/8-1:0]                s_wstrobe,
    output logic [DATA_WIDTH-1:0]                  s_wdata,
    input  logic                                   s_ready,
    input  logic [DATA_WIDTH-1:0]                  s_rdata,
    input  logic                                   s_irq,
    output logic                                   busy,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant,
    output logic                                   timeout_err
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_reg;
    logic [GW-1:0]   grant_reg;
    logic [CW-1:0]   cnt_reg;

    logic [ADDR_WIDTH-1:0] addr_arr  [N_REQ];
    logic [SW-1:0]         strb_arr  [N_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign addr_arr[gi]  = m_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign strb_arr[gi]  = m_wstrobe[gi*SW +: SW];
            assign wdata_arr[gi] = m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic          active;
    logic          gvalid;
    logic          timeout_hit;
    logic          pick_found;
    logic [GW-1:0] pick_idx;
    logic [GW:0]   sum;

    // Outputs are gated by reset so nothing leaks out while reset is held low.
    assign active      = (state_reg == BUSY) && reset;
    assign gvalid      = m_valid[grant_reg];
    assign timeout_hit = TIMEOUT_EN && active && gvalid && !s_ready
                         && (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

    // Walk from farthest to nearest so the nearest valid requester after grant wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        sum        = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            sum = {1'b0, grant_reg} + (GW+1)'(k);
            if (sum >= (GW+1)'(N_REQ)) begin
                sum = sum - (GW+1)'(N_REQ);
            end
            if (m_valid[sum[GW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = sum[GW-1:0];
            end
        end
    end

    always_comb begin
        m_ready = '0;
        if (active && gvalid && (s_ready || timeout_hit)) begin
            m_ready[grant_reg] = 1'b1;
        end
    end

    assign s_valid     = active && gvalid && !timeout_hit;
    assign s_address   = addr_arr[grant_reg];
    assign s_wstrobe   = strb_arr[grant_reg];
    assign s_wdata     = wdata_arr[grant_reg];
    assign m_rdata     = timeout_hit ? '1 : s_rdata;
    assign timeout_err = timeout_hit;
    assign m_irq       = {N_REQ{s_irq}};
    assign busy        = (state_reg == BUSY);
    assign grant       = grant_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            grant_reg <= GW'(N_REQ - 1);
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (pick_found) begin
                        grant_reg <= pick_idx;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (!gvalid || s_ready || timeout_hit) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vermibus_arbiter.sv
// Randomized bench: a transaction-level requester/responder model predicts every completion,
// and a negedge monitor checks each m_ready pulse against the predicted queue.
module tb_vermibus_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    m_valid;
    logic [N*AW-1:0] m_address;
    logic [N*SW-1:0] m_wstrobe;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]    m_ready;
    logic [DW-1:0]   m_rdata;
    logic [N-1:0]    m_irq;
    logic            s_valid;
    logic [AW-1:0]   s_address;
    logic [SW-1:0]   s_wstrobe;
    logic [DW-1:0]   s_wdata;
    logic            s_ready;
    logic [DW-1:0]   s_rdata;
    logic            s_irq;
    logic            busy;
    logic [0:0]      grant;
    logic            timeout_err;

    vermibus_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_address(m_address),
        .m_wstrobe(m_wstrobe), .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata),
        .m_irq(m_irq), .s_valid(s_valid), .s_address(s_address), .s_wstrobe(s_wstrobe),
        .s_wdata(s_wdata), .s_ready(s_ready), .s_rdata(s_rdata), .s_irq(s_irq),
        .busy(busy), .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          w;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic [31:0] r;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 0;
    bit   exp_busy = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic int rr(input int l, input logic [N-1:0] v);
        logic [N-1:0] t;
        for (int k = 1; k <= N; k++) begin
            t = v >> ((l + k) % N);
            if (t[0]) return (l + k) % N;
        end
        return -1;
    endfunction

    // Monitor: every completion must match the oldest prediction.
    exp_t e;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("irq", 64'(m_irq), 64'({N{s_irq}}));
            if (m_ready != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 64'(m_ready), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("ready_onehot", 64'(m_ready), 64'(1) << e.w);
                    chk("grant", 64'(grant), 64'(e.w));
                    chk("rdata", 64'(m_rdata), 64'(e.r));
                    chk("timeout_err", 64'(timeout_err), 64'(e.to));
                    chk("s_valid", 64'(s_valid), 64'(!e.to));
                    if (!e.to) begin
                        chk("s_address", 64'(s_address), 64'(e.a));
                        chk("s_wstrobe", 64'(s_wstrobe), 64'(e.s));
                        chk("s_wdata", 64'(s_wdata), 64'(e.d));
                    end
                    $display("txn req=%0d addr=%h strb=%h wdata=%h rdata=%h timeout=%0d",
                             e.w, e.a, e.s, e.d, m_rdata, timeout_err);
                end
            end else begin
                chk("timeout_err_quiet", 64'(timeout_err), 64'(0));
            end
        end
    end

    bit          mb, drop_pending, raise_en;
    int          mw, mk, mdelay, last, drop_w;
    logic [31:0] mrdata;
    exp_t        ne;

    initial begin
        reset = 1'b0; m_valid = '0; m_address = '0; m_wstrobe = '0; m_wdata = '0;
        s_ready = 1'b0; s_rdata = '0; s_irq = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_s_valid", 64'(s_valid), 64'(0));
        chk("rst_m_ready", 64'(m_ready), 64'(0));
        chk("rst_timeout", 64'(timeout_err), 64'(0));
        chk("rst_grant", 64'(grant), 64'(N - 1));

        @(posedge clk); #1;
        reset = 1'b1; last = N - 1; mb = 0; drop_pending = 0; raise_en = 1;
        exp_busy = 0; mon_en = 1;

        for (int c = 0; c < 3040; c++) begin
            @(posedge clk); #1;
            if (c == 3000) raise_en = 0;
            if (drop_pending) begin
                m_valid = m_valid & ~(N'(1) << drop_w);
                drop_pending = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (raise_en && ((m_valid >> i) & N'(1)) == '0 && $urandom_range(0, 2) == 0) begin
                    m_valid = m_valid | (N'(1) << i);
                    m_address[i*AW +: AW] = $urandom;
                    m_wstrobe[i*SW +: SW] = 4'($urandom);
                    m_wdata[i*DW +: DW]   = $urandom;
                end
            end
            s_irq = 1'($urandom);
            exp_busy = mb;
            if (mb) begin
                mk++;
                s_ready = (mk == mdelay);
                s_rdata = mrdata;
                if (mk == mdelay || mk == TO) begin
                    mb = 0; drop_pending = 1; drop_w = mw;
                end
            end else begin
                s_ready = 1'b0;
                s_rdata = $urandom;
                if (m_valid != '0) begin
                    mw = rr(last, m_valid); last = mw;
                    mb = 1; mk = 0;
                    mdelay = $urandom_range(1, TO + 1);
                    mrdata = $urandom;
                    ne.w  = mw;
                    ne.a  = m_address[mw*AW +: AW];
                    ne.s  = m_wstrobe[mw*SW +: SW];
                    ne.d  = m_wdata[mw*DW +: DW];
                    ne.to = (mdelay > TO);
                    ne.r  = ne.to ? 32'hFFFF_FFFF : mrdata;
                    sb.push_back(ne);
                end
            end
        end
        @(negedge clk);
        mon_en = 0;
        chk("sb_drained", 64'(sb.size()), 64'(0));
        chk("all_served", 64'(m_valid), 64'(0));

        // Requester abort: dropping valid mid-transfer ends it silently.
        @(posedge clk); #1; s_ready = 1'b0; m_valid = 2'b01;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'(1));
        chk("abort_grant", 64'(grant), 64'(0));
        chk("abort_s_valid", 64'(s_valid), 64'(1));
        @(posedge clk); #1; m_valid = 2'b00;
        @(negedge clk);
        chk("abort_no_ready", 64'(m_ready), 64'(0));
        chk("abort_no_timeout", 64'(timeout_err), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_idle", 64'(busy), 64'(0));

        // Reset while a transfer is stalled in BUSY.
        @(posedge clk); #1; m_valid = 2'b10;
        @(posedge clk); #1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("rstb_s_valid", 64'(s_valid), 64'(0));
        chk("rstb_m_ready", 64'(m_ready), 64'(0));
        @(posedge clk); #1; reset = 1'b1; m_valid = 2'b11;
        @(negedge clk);
        chk("rstb_busy", 64'(busy), 64'(0));
        chk("rstb_idle_s_valid", 64'(s_valid), 64'(0));
        chk("rstb_grant", 64'(grant), 64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstb_first_grant", 64'(grant), 64'(0));
        chk("rstb_busy_again", 64'(busy), 64'(1));
        chk("rstb_fwd_valid", 64'(s_valid), 64'(1));
        @(posedge clk); #1; m_valid = 2'b00;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
